// File: rtl/ibex_fpu_pkg.sv
// rtl/ibex_fpu_pkg.sv - shared types and constants for the FP register file
// Write-port indices give the fixed priority order: FPU writeback beats FP load.
package ibex_fpu_pkg;

  localparam int unsigned FRegAddrW = 5;
  localparam int unsigned FRegDataW = 32;
  localparam int unsigned NumFRegs  = 2 ** FRegAddrW;

  localparam int unsigned FRegWbFpu  = 0;
  localparam int unsigned FRegWbLoad = 1;

  typedef logic [FRegAddrW-1:0] freg_addr_t;
  typedef logic [FRegDataW-1:0] freg_data_t;

endpackage

// File: rtl/ibex_freg_scoreboard.sv
// rtl/ibex_freg_scoreboard.sv - per-register busy bits, pending count and unreserved-write flag
// Issue acceptance is combinational; all tracking state updates on the rising clock edge.
module ibex_freg_scoreboard
  import ibex_fpu_pkg::*;
#(
  parameter int unsigned AddrWidth = 5,
  parameter int unsigned NumWrite  = 2
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NumWrite-1:0][AddrWidth-1:0] waddr_i,
  input  logic [NumWrite-1:0]                we_i,
  input  logic                               issue_valid_i,
  input  logic [AddrWidth-1:0]               issue_addr_i,
  input  logic                               flush_i,
  output logic                               issue_ready_o,
  output logic [(2**AddrWidth)-1:0]          busy_o,
  output logic [AddrWidth:0]                 pending_cnt_o,
  output logic                               err_o
);

  localparam int unsigned NumWords = 2 ** AddrWidth;

  logic [NumWords-1:0] busy_q, busy_d;
  logic [AddrWidth:0]  cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                issue_ok;

  // Refuse reservations of busy registers (WAW), and everything during flush or reset.
  assign issue_ok = issue_valid_i & ~busy_q[issue_addr_i] & ~flush_i & ~rst_i;

  always_comb begin
    busy_d = busy_q;
    err_d  = err_q;
    cnt_d  = '0;
    for (int p = 0; p < NumWrite; p++) begin
      if (we_i[p]) begin
        busy_d[waddr_i[p]] = 1'b0;
        if (!busy_q[waddr_i[p]]) begin
          err_d = 1'b1;
        end
      end
    end
    // A same-cycle reservation outlives the write that would clear it.
    if (issue_ok) begin
      busy_d[issue_addr_i] = 1'b1;
    end
    if (flush_i) begin
      busy_d = '0;
    end
    for (int i = 0; i < NumWords; i++) begin
      cnt_d = cnt_d + {{AddrWidth{1'b0}}, busy_d[i]};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign issue_ready_o = issue_ok;
  assign busy_o        = busy_q;
  assign pending_cnt_o = cnt_q;
  assign err_o         = err_q;

endmodule

// File: rtl/ibex_freg_file_sb.sv
// rtl/ibex_freg_file_sb.sv - FP register file with write-reservation scoreboard
// Optional macro IBEX_FRF_BYPASS_EN forwards same-cycle write data to the read ports.
module ibex_freg_file_sb
  import ibex_fpu_pkg::*;
#(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 5,
  parameter int unsigned NumRead   = 3,
  parameter int unsigned NumWrite  = 2
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NumRead-1:0][AddrWidth-1:0]  raddr_i,
  output logic [NumRead-1:0][DataWidth-1:0]  rdata_o,
  output logic [NumRead-1:0]                 rbusy_o,
  input  logic [NumWrite-1:0][AddrWidth-1:0] waddr_i,
  input  logic [NumWrite-1:0][DataWidth-1:0] wdata_i,
  input  logic [NumWrite-1:0]                we_i,
  input  logic                               issue_valid_i,
  input  logic [AddrWidth-1:0]               issue_addr_i,
  output logic                               issue_ready_o,
  input  logic                               flush_i,
  output logic [AddrWidth:0]                 pending_cnt_o,
  output logic                               err_o
);

  localparam int unsigned NumWords = 2 ** AddrWidth;

  logic [DataWidth-1:0] mem_q [NumWords];
  logic [DataWidth-1:0] mem_d [NumWords];
  logic [NumWords-1:0]  busy;

  // Highest port index applied first so FRegWbFpu (port 0) lands last and wins.
  always_comb begin
    mem_d = mem_q;
    for (int p = NumWrite - 1; p >= 0; p--) begin
      if (we_i[p]) begin
        mem_d[waddr_i[p]] = wdata_i[p];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumWords; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    for (int k = 0; k < NumRead; k++) begin
      rdata_o[k] = mem_q[raddr_i[k]];
      rbusy_o[k] = busy[raddr_i[k]];
`ifdef IBEX_FRF_BYPASS_EN
      for (int p = NumWrite - 1; p >= 0; p--) begin
        if (we_i[p] && !rst_i && (waddr_i[p] == raddr_i[k])) begin
          rdata_o[k] = wdata_i[p];
          rbusy_o[k] = 1'b0;
        end
      end
`endif
    end
  end

  ibex_freg_scoreboard #(
    .AddrWidth (AddrWidth),
    .NumWrite  (NumWrite)
  ) u_scoreboard (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .waddr_i       (waddr_i),
    .we_i          (we_i),
    .issue_valid_i (issue_valid_i),
    .issue_addr_i  (issue_addr_i),
    .flush_i       (flush_i),
    .issue_ready_o (issue_ready_o),
    .busy_o        (busy),
    .pending_cnt_o (pending_cnt_o),
    .err_o         (err_o)
  );

endmodule

// File: tb/tb_ibex_freg_file_sb.sv
// tb/tb_ibex_freg_file_sb.sv - directed table-driven bench for ibex_freg_file_sb
module tb_ibex_freg_file_sb;

  localparam bit BYP =
`ifdef IBEX_FRF_BYPASS_EN
    1'b1;
`else
    1'b0;
`endif

  logic             clk_i;
  logic             rst_i;
  logic [2:0][4:0]  raddr_i;
  logic [2:0][31:0] rdata_o;
  logic [2:0]       rbusy_o;
  logic [1:0][4:0]  waddr_i;
  logic [1:0][31:0] wdata_i;
  logic [1:0]       we_i;
  logic             issue_valid_i;
  logic [4:0]       issue_addr_i;
  logic             issue_ready_o;
  logic             flush_i;
  logic [5:0]       pending_cnt_o;
  logic             err_o;

  int checks = 0;
  int errors = 0;

  ibex_freg_file_sb #(
    .DataWidth (32),
    .AddrWidth (5),
    .NumRead   (3),
    .NumWrite  (2)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .raddr_i       (raddr_i),
    .rdata_o       (rdata_o),
    .rbusy_o       (rbusy_o),
    .waddr_i       (waddr_i),
    .wdata_i       (wdata_i),
    .we_i          (we_i),
    .issue_valid_i (issue_valid_i),
    .issue_addr_i  (issue_addr_i),
    .issue_ready_o (issue_ready_o),
    .flush_i       (flush_i),
    .pending_cnt_o (pending_cnt_o),
    .err_o         (err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    int unsigned we0, wa0, wd0, we1, wa1, wd1, iv, ia, fl, ra;
    int unsigned ready, rdata, rbusy, cnt, err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int unsigned we0, wa0, wd0, we1, wa1, wd1,
                              input int unsigned iv, ia, fl, ra,
                              input int unsigned ready, rdata, rbusy, cnt, err);
    vec_t v;
    v.we0 = we0; v.wa0 = wa0; v.wd0 = wd0; v.we1 = we1; v.wa1 = wa1; v.wd1 = wd1;
    v.iv = iv; v.ia = ia; v.fl = fl; v.ra = ra;
    v.ready = ready; v.rdata = rdata; v.rbusy = rbusy; v.cnt = cnt; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    we_i          = '0;
    waddr_i       = '0;
    wdata_i       = '0;
    issue_valid_i = 1'b0;
    issue_addr_i  = '0;
    flush_i       = 1'b0;
  endtask

  task automatic set_raddr(input logic [4:0] a);
    for (int k = 0; k < 3; k++) raddr_i[k] = a;
  endtask

  initial begin
    rst_i = 1'b1;
    idle();
    set_raddr(5'd0);
    issue_valid_i = 1'b1;
    #12;
    chk("reset ready", 32'(issue_ready_o), 32'd0);
    chk("reset cnt",   32'(pending_cnt_o), 32'd0);
    chk("reset err",   32'(err_o), 32'd0);
    chk("reset rdata", rdata_o[0], 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    idle();

    //          we0 wa0 wd0           we1 wa1 wd1           iv ia fl ra  ready rdata                                    rbusy        cnt err
    vecs.push_back(mk(1, 0, 32'h3F800000, 0, 0, 0,            0, 0, 0, 0,  0, BYP ? 32'h3F800000 : 32'h0,             0,           0, 1));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0, 0, 0,  0, 32'h3F800000,                           0,           0, 1));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,            1, 5, 0, 5,  1, 32'h0,                                  0,           1, 1));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,            1, 5, 0, 5,  0, 32'h0,                                  1,           1, 1));
    vecs.push_back(mk(0, 0, 0,            1, 5, 32'h40490FDB, 0, 0, 0, 5,  0, BYP ? 32'h40490FDB : 32'h0,             BYP ? 0 : 1, 0, 1));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0, 0, 5,  0, 32'h40490FDB,                           0,           0, 1));
    vecs.push_back(mk(1, 7, 32'h1,        1, 7, 32'h2,        0, 0, 0, 7,  0, BYP ? 32'h1 : 32'h0,                    0,           0, 1));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0, 0, 7,  0, 32'h1,                                  0,           0, 1));
    vecs.push_back(mk(1, 3, 32'h12345678, 0, 0, 0,            1, 3, 0, 3,  1, BYP ? 32'h12345678 : 32'h0,             0,           1, 1));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0, 0, 3,  0, 32'h12345678,                           1,           1, 1));
    vecs.push_back(mk(0, 0, 0,            1, 3, 32'hAAAA5555, 1, 6, 0, 3,  1, BYP ? 32'hAAAA5555 : 32'h12345678,      BYP ? 0 : 1, 1, 1));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,            1, 1, 0, 6,  1, 32'h0,                                  1,           2, 1));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,            1, 2, 0, 1,  1, 32'h0,                                  1,           3, 1));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,            1, 4, 0, 2,  1, 32'h0,                                  1,           4, 1));
    vecs.push_back(mk(1, 1, 32'hDEADBEEF, 0, 0, 0,            1, 8, 1, 4,  0, 32'h0,                                  1,           0, 1));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0, 0, 1,  0, 32'hDEADBEEF,                           0,           0, 1));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0, 0, 3,  0, 32'hAAAA5555,                           0,           0, 1));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,            1, 8, 0, 8,  1, 32'h0,                                  0,           1, 1));
    vecs.push_back(mk(1, 9, 32'hC0000000, 0, 0, 0,            0, 0, 0, 9,  0, BYP ? 32'hC0000000 : 32'h0,             0,           1, 1));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0, 0, 9,  0, 32'hC0000000,                           0,           1, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      @(negedge clk_i);
      we_i[0]       = v.we0[0];
      waddr_i[0]    = v.wa0[4:0];
      wdata_i[0]    = v.wd0;
      we_i[1]       = v.we1[0];
      waddr_i[1]    = v.wa1[4:0];
      wdata_i[1]    = v.wd1;
      issue_valid_i = v.iv[0];
      issue_addr_i  = v.ia[4:0];
      flush_i       = v.fl[0];
      set_raddr(v.ra[4:0]);
      #1;
      chk($sformatf("row%0d ready", i),  32'(issue_ready_o), v.ready);
      chk($sformatf("row%0d rdata0", i), rdata_o[0], v.rdata);
      chk($sformatf("row%0d rdata2", i), rdata_o[2], v.rdata);
      chk($sformatf("row%0d rbusy0", i), 32'(rbusy_o[0]), v.rbusy);
      @(posedge clk_i);
      #1;
      chk($sformatf("row%0d cnt", i), 32'(pending_cnt_o), v.cnt);
      chk($sformatf("row%0d err", i), 32'(err_o), v.err);
    end

    // Asynchronous reset between edges while f8 is reserved and f9 holds data.
    @(negedge clk_i);
    idle();
    issue_valid_i = 1'b1;
    issue_addr_i  = 5'd9;
    set_raddr(5'd9);
    #2;
    rst_i = 1'b1;
    #1;
    chk("async cnt",   32'(pending_cnt_o), 32'd0);
    chk("async err",   32'(err_o), 32'd0);
    chk("async rdata", rdata_o[0], 32'd0);
    chk("async ready", 32'(issue_ready_o), 32'd0);
    set_raddr(5'd8);
    #1;
    chk("async rbusy f8", 32'(rbusy_o[0]), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    idle();

    // Reserved write keeps err clear; a later unreserved write sets it for good.
    @(negedge clk_i);
    issue_valid_i = 1'b1;
    issue_addr_i  = 5'd10;
    @(posedge clk_i);
    #1;
    chk("resv cnt", 32'(pending_cnt_o), 32'd1);
    @(negedge clk_i);
    idle();
    we_i[1]    = 1'b1;
    waddr_i[1] = 5'd10;
    wdata_i[1] = 32'h00000055;
    set_raddr(5'd10);
    @(posedge clk_i);
    #1;
    chk("resv wr cnt", 32'(pending_cnt_o), 32'd0);
    chk("resv wr err", 32'(err_o), 32'd0);
    chk("resv rdata",  rdata_o[1], 32'h00000055);
    @(negedge clk_i);
    idle();
    we_i[0]    = 1'b1;
    waddr_i[0] = 5'd11;
    wdata_i[0] = 32'h1;
    @(posedge clk_i);
    #1;
    chk("unresv err", 32'(err_o), 32'd1);
    @(negedge clk_i);
    idle();
    @(posedge clk_i);
    #1;
    chk("sticky err", 32'(err_o), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
